// File: rtl/pac_motion_ctrl.sv
// Pac-Man movement engine: buffered direction requests, two-corner wall probes through a registered
// Map address, fallback to the current heading, one STEP move per tick. Optional `PAC_TUNNEL_WRAP_EN.
module pac_motion_ctrl #(
  parameter int TICK_CYCLES = 250000,
  parameter int STEP        = 1,
  parameter int START_X     = 304,
  parameter int START_Y     = 240,
  parameter int X_MAX       = 608,
  parameter int Y_MAX       = 448
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_en,
  input  logic [3:0] dir_req,
  input  logic       probe_wall,
  output logic [8:0] probe_row,
  output logic [9:0] probe_col,
  output logic [9:0] PacX,
  output logic [8:0] PacY,
  output logic [1:0] state,
  output logic       moved
);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam int CNT_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  localparam logic signed [10:0] STEP_S  = 11'(STEP);
  localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
  localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);
  localparam logic signed [10:0] SPAN    = 11'sd31;

  typedef enum logic [2:0] {S_IDLE, S_RA, S_RB, S_CA, S_CB, S_CM, S_STOP} fsm_e;

  // skip: target is off-screen, Map is not addressed; skip_blk is the verdict used instead.
  typedef struct packed {
    logic [8:0] row;
    logic [9:0] col;
    logic       skip;
    logic       skip_blk;
  } probe_t;

  function automatic logic signed [10:0] tgt_x(input logic [1:0] d, input logic signed [10:0] px_i);
    case (d)
      DIR_RIGHT: return px_i + STEP_S;
      DIR_LEFT:  return px_i - STEP_S;
      default:   return px_i;
    endcase
  endfunction

  function automatic logic signed [10:0] tgt_y(input logic [1:0] d, input logic signed [10:0] py_i);
    case (d)
      DIR_UP:   return py_i - STEP_S;
      DIR_DOWN: return py_i + STEP_S;
      default:  return py_i;
    endcase
  endfunction

  // Leading-edge corner of the sprite at its target position; bounds are judged on the target.
  function automatic probe_t probe_at(input logic [1:0] d, input logic pt_b,
                                      input logic signed [10:0] tx, input logic signed [10:0] ty);
    logic signed [10:0] off;
    logic signed [10:0] r;
    logic signed [10:0] c;
    logic               h_oob;
    logic               v_oob;
    probe_t             p;
    off = pt_b ? SPAN : 11'sd0;
    r   = ty;
    c   = tx;
    case (d)
      DIR_UP:    c = tx + off;
      DIR_DOWN:  begin r = ty + SPAN; c = tx + off; end
      DIR_RIGHT: begin r = ty + off;  c = tx + SPAN; end
      default:   r = ty + off;
    endcase
    h_oob  = (tx < 11'sd0) || (tx > X_MAX_S);
    v_oob  = (ty < 11'sd0) || (ty > Y_MAX_S);
    p.row  = 9'(r);
    p.col  = 10'(c);
    p.skip = h_oob | v_oob;
`ifdef PAC_TUNNEL_WRAP_EN
    p.skip_blk = v_oob;
`else
    p.skip_blk = 1'b1;
`endif
    return p;
  endfunction

  function automatic logic [9:0] wrap_x(input logic signed [10:0] tx);
`ifdef PAC_TUNNEL_WRAP_EN
    if (tx < 11'sd0) return 10'(X_MAX);
    if (tx > X_MAX_S) return 10'd0;
`endif
    return 10'(tx);
  endfunction

  fsm_e             fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       req_dir_q, req_dir_d;
  logic [1:0]       cur_dir_q, cur_dir_d;
  logic [1:0]       try_dir_q, try_dir_d;
  logic             blk_a_q, blk_a_d;
  logic             skip_q, skip_d;
  logic             skip_blk_q, skip_blk_d;
  logic [8:0]       probe_row_q, probe_row_d;
  logic [9:0]       probe_col_q, probe_col_d;
  logic [9:0]       pac_x_q, pac_x_d;
  logic [8:0]       pac_y_q, pac_y_d;
  logic             moved_q, moved_d;

  logic               tick;
  logic               wall_now;
  logic               load_probe;
  logic [1:0]         pr_dir;
  logic               pr_b;
  logic signed [10:0] px;
  logic signed [10:0] py;
  probe_t             pr;

  assign px       = signed'({1'b0, pac_x_q});
  assign py       = signed'({2'b00, pac_y_q});
  assign wall_now = skip_q ? skip_blk_q : probe_wall;

  // Motion tick and request buffer
  always_comb begin
    tick = game_en && (cnt_q == CNT_LAST);
    if (!game_en || tick) cnt_d = '0;
    else                  cnt_d = cnt_q + CNT_W'(1);

    req_dir_d = req_dir_q;
    if      (dir_req[3]) req_dir_d = DIR_UP;
    else if (dir_req[2]) req_dir_d = DIR_DOWN;
    else if (dir_req[1]) req_dir_d = DIR_RIGHT;
    else if (dir_req[0]) req_dir_d = DIR_LEFT;
  end

  // Probe address for the state about to be entered
  always_comb begin
    pr_dir = req_dir_q;
    pr_b   = 1'b0;
    case (fsm_q)
      S_RA:    begin pr_dir = try_dir_q; pr_b = 1'b1; end
      S_RB:    begin pr_dir = cur_dir_q; pr_b = 1'b0; end
      S_CA:    begin pr_dir = try_dir_q; pr_b = 1'b1; end
      default: begin pr_dir = req_dir_q; pr_b = 1'b0; end
    endcase
    pr = probe_at(pr_dir, pr_b, tgt_x(pr_dir, px), tgt_y(pr_dir, py));
  end

  // Probe sequencer: requested dir, then current dir, then commit or stop
  always_comb begin
    fsm_d       = fsm_q;
    try_dir_d   = try_dir_q;
    cur_dir_d   = cur_dir_q;
    blk_a_d     = blk_a_q;
    pac_x_d     = pac_x_q;
    pac_y_d     = pac_y_q;
    moved_d     = 1'b0;
    load_probe  = 1'b0;
    skip_d      = skip_q;
    skip_blk_d  = skip_blk_q;
    probe_row_d = probe_row_q;
    probe_col_d = probe_col_q;

    if (game_en) begin
      case (fsm_q)
        S_IDLE: begin
          if (tick) begin
            fsm_d      = S_RA;
            try_dir_d  = req_dir_q;
            load_probe = 1'b1;
          end
        end
        S_RA: begin
          blk_a_d    = wall_now;
          load_probe = 1'b1;
          fsm_d      = S_RB;
        end
        S_RB: begin
          if (!blk_a_q && !wall_now) begin
            fsm_d = S_CM;
          end else if (try_dir_q == cur_dir_q) begin
            fsm_d = S_STOP;
          end else begin
            fsm_d      = S_CA;
            try_dir_d  = cur_dir_q;
            load_probe = 1'b1;
          end
        end
        S_CA: begin
          blk_a_d    = wall_now;
          load_probe = 1'b1;
          fsm_d      = S_CB;
        end
        S_CB: begin
          fsm_d = (!blk_a_q && !wall_now) ? S_CM : S_STOP;
        end
        S_CM: begin
          pac_x_d   = wrap_x(tgt_x(try_dir_q, px));
          pac_y_d   = 9'(tgt_y(try_dir_q, py));
          cur_dir_d = try_dir_q;
          moved_d   = 1'b1;
          fsm_d     = S_IDLE;
        end
        default: fsm_d = S_IDLE;
      endcase
    end else begin
      fsm_d = S_IDLE;
    end

    if (load_probe) begin
      skip_d     = pr.skip;
      skip_blk_d = pr.skip_blk;
      if (!pr.skip) begin
        probe_row_d = pr.row;
        probe_col_d = pr.col;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= S_IDLE;
      cnt_q       <= '0;
      req_dir_q   <= DIR_RIGHT;
      cur_dir_q   <= DIR_RIGHT;
      try_dir_q   <= DIR_RIGHT;
      blk_a_q     <= 1'b0;
      skip_q      <= 1'b0;
      skip_blk_q  <= 1'b0;
      probe_row_q <= '0;
      probe_col_q <= '0;
      pac_x_q     <= 10'(START_X);
      pac_y_q     <= 9'(START_Y);
      moved_q     <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      req_dir_q   <= req_dir_d;
      cur_dir_q   <= cur_dir_d;
      try_dir_q   <= try_dir_d;
      blk_a_q     <= blk_a_d;
      skip_q      <= skip_d;
      skip_blk_q  <= skip_blk_d;
      probe_row_q <= probe_row_d;
      probe_col_q <= probe_col_d;
      pac_x_q     <= pac_x_d;
      pac_y_q     <= pac_y_d;
      moved_q     <= moved_d;
    end
  end

  assign probe_row = probe_row_q;
  assign probe_col = probe_col_q;
  assign PacX      = pac_x_q;
  assign PacY      = pac_y_q;
  assign state     = cur_dir_q;
  assign moved     = moved_q;

endmodule

// File: tb/tb_pac_motion_ctrl.sv
// Directed bench for pac_motion_ctrl with TICK_CYCLES=8 and a model Map whose wall band is rows 200-207.
module tb_pac_motion_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       game_en;
  logic [3:0] dir_req;
  logic       probe_wall;
  logic [8:0] probe_row;
  logic [9:0] probe_col;
  logic [9:0] PacX;
  logic [8:0] PacY;
  logic [1:0] state;
  logic       moved;
  logic       band_en;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign probe_wall = band_en && (probe_row >= 9'd200) && (probe_row <= 9'd207);

  pac_motion_ctrl #(.TICK_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .game_en(game_en), .dir_req(dir_req), .probe_wall(probe_wall),
    .probe_row(probe_row), .probe_col(probe_col), .PacX(PacX), .PacY(PacY),
    .state(state), .moved(moved)
  );

  task automatic wait_moved(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (moved) begin ok = 1'b1; break; end
    end
  endtask

  task automatic press(input logic [3:0] v);
    @(negedge clk); dir_req = v;
    @(negedge clk); dir_req = 4'b0000;
  endtask

  task automatic test_reset();
    int mv;
    rst = 1'b1; game_en = 1'b0; dir_req = 4'b0000; band_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    checks++; if (PacX !== 10'd304) begin errors++; $display("FAIL reset_pacx: got %0d expected 304", PacX); end
    checks++; if (PacY !== 9'd240) begin errors++; $display("FAIL reset_pacy: got %0d expected 240", PacY); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL reset_state: got %b expected 10", state); end
    checks++; if (moved !== 1'b0) begin errors++; $display("FAIL reset_moved: got %b expected 0", moved); end
    checks++; if (probe_row !== 9'd0 || probe_col !== 10'd0) begin errors++; $display("FAIL reset_probe: got %0d/%0d expected 0/0", probe_row, probe_col); end
    dir_req = 4'b0001;
    mv = 0;
    repeat (100) begin @(negedge clk); if (moved) mv++; end
    dir_req = 4'b0000;
    checks++; if (mv !== 0) begin errors++; $display("FAIL idle_moved: got %0d pulses expected 0", mv); end
    checks++; if (PacX !== 10'd304 || PacY !== 9'd240) begin errors++; $display("FAIL idle_pos: got %0d,%0d expected 304,240", PacX, PacY); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL idle_state: got %b expected 10", state); end
  endtask

  task automatic test_free_move();
    int e0, prev;
    bit ok;
    @(negedge clk); dir_req = 4'b0010; game_en = 1'b1; e0 = cyc;
    wait_moved(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL move1_timeout: got no moved expected pulse"); end
    checks++; if (cyc - e0 !== 11) begin errors++; $display("FAIL move1_latency: got %0d expected 11", cyc - e0); end
    checks++; if (PacX !== 10'd305 || PacY !== 9'd240) begin errors++; $display("FAIL move1_pos: got %0d,%0d expected 305,240", PacX, PacY); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL move1_state: got %b expected 10", state); end
    checks++; if (probe_row !== 9'd271 || probe_col !== 10'd336) begin errors++; $display("FAIL move1_probe: got %0d/%0d expected 271/336", probe_row, probe_col); end
    dir_req = 4'b0000;
    prev = cyc;
    @(negedge clk);
    checks++; if (moved !== 1'b0) begin errors++; $display("FAIL moved_width: got %b expected 0", moved); end
    for (int k = 2; k <= 3; k++) begin
      wait_moved(12, ok);
      checks++; if (!ok || cyc - prev !== 8) begin errors++; $display("FAIL move%0d_period: got %0d expected 8", k, cyc - prev); end
      checks++; if (PacX !== 10'(304 + k)) begin errors++; $display("FAIL move%0d_pacx: got %0d expected %0d", k, PacX, 304 + k); end
      prev = cyc;
    end
  endtask

  task automatic test_up_to_band();
    bit ok;
    int mv;
    press(4'b1000);
    wait_moved(20, ok);
    checks++; if (!ok || PacY !== 9'd239 || state !== 2'b00) begin errors++; $display("FAIL up1: got y=%0d st=%b expected y=239 st=00", PacY, state); end
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (PacY == 9'd208) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL up_reach: got y=%0d expected 208", PacY); end
    mv = 0;
    repeat (24) begin @(negedge clk); if (moved) mv++; end
    checks++; if (mv !== 0 || PacY !== 9'd208) begin errors++; $display("FAIL band_stop: got %0d moves y=%0d expected 0 moves y=208", mv, PacY); end
    checks++; if (PacX !== 10'd307 || state !== 2'b00) begin errors++; $display("FAIL band_stop_x: got x=%0d st=%b expected 307 st=00", PacX, state); end
  endtask

  task automatic test_buffered_turn();
    bit ok;
    int m1, m2;
    press(4'b0010);
    wait_moved(20, ok); m1 = cyc;
    checks++; if (!ok || PacX !== 10'd308 || PacY !== 9'd208 || state !== 2'b10) begin errors++; $display("FAIL turn_right: got %0d,%0d st=%b expected 308,208 st=10", PacX, PacY, state); end
    press(4'b1000);
    wait_moved(20, ok); m2 = cyc;
    checks++; if (!ok || m2 - m1 !== 10) begin errors++; $display("FAIL fallback_latency: got %0d expected 10", m2 - m1); end
    checks++; if (PacX !== 10'd309 || PacY !== 9'd208 || state !== 2'b10) begin errors++; $display("FAIL fallback_pos: got %0d,%0d st=%b expected 309,208 st=10", PacX, PacY, state); end
    band_en = 1'b0;
    wait_moved(20, ok);
    checks++; if (!ok || cyc - m2 !== 6) begin errors++; $display("FAIL turn_latency: got %0d expected 6", cyc - m2); end
    checks++; if (PacX !== 10'd309 || PacY !== 9'd207 || state !== 2'b00) begin errors++; $display("FAIL turn_up: got %0d,%0d st=%b expected 309,207 st=00", PacX, PacY, state); end
    band_en = 1'b1;
  endtask

  task automatic test_dead_end();
    int mv;
    press(4'b0010);
    mv = 0;
    repeat (30) begin @(negedge clk); if (moved) mv++; end
    checks++; if (mv !== 0) begin errors++; $display("FAIL dead_moved: got %0d pulses expected 0", mv); end
    checks++; if (PacX !== 10'd309 || PacY !== 9'd207 || state !== 2'b00) begin errors++; $display("FAIL dead_pos: got %0d,%0d st=%b expected 309,207 st=00", PacX, PacY, state); end
    checks++; if (probe_row !== 9'd206 || probe_col !== 10'd340) begin errors++; $display("FAIL dead_probe: got %0d/%0d expected 206/340", probe_row, probe_col); end
  endtask

  task automatic test_edge();
    bit ok;
    int mv;
    press(4'b0111);
    wait_moved(20, ok);
    checks++; if (!ok || PacY !== 9'd208 || state !== 2'b01) begin errors++; $display("FAIL down_prio: got y=%0d st=%b expected 208 st=01", PacY, state); end
    press(4'b0001);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (PacX == 10'd0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || state !== 2'b11 || PacY !== 9'd208) begin errors++; $display("FAIL left_reach: got x=%0d st=%b expected 0 st=11", PacX, state); end
`ifdef PAC_TUNNEL_WRAP_EN
    wait_moved(12, ok);
    checks++; if (!ok || PacX !== 10'd608 || state !== 2'b11) begin errors++; $display("FAIL wrap: got x=%0d st=%b expected 608 st=11", PacX, state); end
`else
    mv = 0;
    repeat (24) begin @(negedge clk); if (moved) mv++; end
    checks++; if (mv !== 0 || PacX !== 10'd0 || state !== 2'b11) begin errors++; $display("FAIL edge_block: got %0d moves x=%0d st=%b expected 0 moves x=0 st=11", mv, PacX, state); end
`endif
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    int mv;
    press(4'b0100);
    wait_moved(20, ok);
    checks++; if (!ok || PacY !== 9'd209) begin errors++; $display("FAIL pre_rst_move: got y=%0d expected 209", PacY); end
    repeat (6) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (PacX !== 10'd304 || PacY !== 9'd240) begin errors++; $display("FAIL rst_mid_pos: got %0d,%0d expected 304,240", PacX, PacY); end
    checks++; if (state !== 2'b10 || moved !== 1'b0) begin errors++; $display("FAIL rst_mid_state: got st=%b mv=%b expected 10/0", state, moved); end
    checks++; if (probe_row !== 9'd0 || probe_col !== 10'd0) begin errors++; $display("FAIL rst_mid_probe: got %0d/%0d expected 0/0", probe_row, probe_col); end
    mv = 0;
    repeat (8) begin @(negedge clk); if (moved) mv++; end
    checks++; if (mv !== 0 || PacX !== 10'd304 || PacY !== 9'd240) begin errors++; $display("FAIL rst_no_move: got %0d moves %0d,%0d expected 0 moves 304,240", mv, PacX, PacY); end
    game_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_move();
    test_up_to_band();
    test_buffered_turn();
    test_dead_end();
    test_edge();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
